shrimp_mem_arbiter: RTL and testbench

SHRIMP_MEM_ARBITER -- requirements
Module: shrimp_mem_arbiter

---
 rtl/shrimp_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_shrimp_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shrimp_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-ported memfile.
// Optional: define SHRIMP_ALIGN_CHECK_EN to reject odd-address load/store accesses.
module shrimp_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic              ls_req_write,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_val,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_val
);

    typedef enum logic {
        SRC_IF,
        SRC_LS
    } src_e;

    logic              acc_valid;
    logic              acc_write;
    src_e              acc_src;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [1:0]        starve;
    logic              if_gnt;
    logic              ls_gnt;
    logic              acc_misaligned;
    logic              if_turn;

    // Fetch only wins a contended cycle after three straight LS wins.
    assign if_turn = (starve == 2'd3);
    assign if_gnt  = !reset && if_req_valid && (!ls_req_valid || if_turn);
    assign ls_gnt  = !reset && ls_req_valid && !(if_req_valid && if_turn);

    assign if_req_ready = if_gnt;
    assign ls_req_ready = ls_gnt;

`ifdef SHRIMP_ALIGN_CHECK_EN
    assign acc_misaligned = acc_addr[0] && (acc_src == SRC_LS);
`else
    assign acc_misaligned = 1'b0;
`endif

    // The address/data registers only load on accept, so they hold when idle.
    assign mem_addr      = acc_addr;
    assign mem_write_val = acc_wdata;

    // Gating with reset drops an in-flight store on the edge reset is seen.
    assign mem_write_enable = acc_valid && acc_write && (acc_src == SRC_LS)
                              && !acc_misaligned && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_valid <= 1'b0;
            acc_write <= 1'b0;
            acc_src   <= SRC_IF;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else if (ls_gnt) begin
            acc_valid <= 1'b1;
            acc_write <= ls_req_write;
            acc_src   <= SRC_LS;
            acc_addr  <= ls_req_addr;
            acc_wdata <= ls_req_wdata;
        end else if (if_gnt) begin
            acc_valid <= 1'b1;
            acc_write <= 1'b0;
            acc_src   <= SRC_IF;
            acc_addr  <= if_req_addr;
            acc_wdata <= '0;
        end else begin
            acc_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve <= 2'd0;
        end else if (!if_req_valid || if_gnt) begin
            starve <= 2'd0;
        end else if (ls_gnt && !if_turn) begin
            starve <= starve + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
        end else begin
            if_rsp_valid <= acc_valid && (acc_src == SRC_IF);
            ls_rsp_valid <= acc_valid && (acc_src == SRC_LS);
            if (acc_valid && acc_src == SRC_IF) begin
                if_rsp_data <= mem_read_val;
            end
            if (acc_valid && acc_src == SRC_LS) begin
                ls_rsp_data <= (acc_write || acc_misaligned) ? '0 : mem_read_val;
            end
        end
    end

`ifdef SHRIMP_ALIGN_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ls_rsp_err <= 1'b0;
        end else if (acc_valid && acc_src == SRC_LS) begin
            ls_rsp_err <= acc_misaligned;
        end else begin
            ls_rsp_err <= 1'b0;
        end
    end
`else
    assign ls_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_shrimp_mem_arbiter.sv
// Directed testbench for shrimp_mem_arbiter with a behavioural memfile.
module tb_shrimp_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [7:0]  if_req_addr;
    logic        if_rsp_valid;
    logic [15:0] if_rsp_data;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [7:0]  ls_req_addr;
    logic        ls_req_write;
    logic [15:0] ls_req_wdata;
    logic        ls_rsp_valid;
    logic [15:0] ls_rsp_data;
    logic        ls_rsp_err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_write_val;
    logic        mem_write_enable;
    logic [15:0] mem_read_val;

    logic [15:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    int n_chk;
    int n_fail;
    int we_cnt;
    int if_rsp_cnt;
    int ls_rsp_cnt;

    always #5 clock = ~clock;

    shrimp_mem_arbiter dut (
        .clock(clock),
        .reset(reset),
        .if_req_valid(if_req_valid),
        .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid),
        .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid),
        .ls_req_ready(ls_req_ready),
        .ls_req_addr(ls_req_addr),
        .ls_req_write(ls_req_write),
        .ls_req_wdata(ls_req_wdata),
        .ls_rsp_valid(ls_rsp_valid),
        .ls_rsp_data(ls_rsp_data),
        .ls_rsp_err(ls_rsp_err),
        .mem_addr(mem_addr),
        .mem_write_val(mem_write_val),
        .mem_write_enable(mem_write_enable),
        .mem_read_val(mem_read_val)
    );

    assign mem_read_val = mem[mem_addr];

    always @(posedge clock) begin
        if (mem_write_enable) mem[mem_addr] <= mem_write_val;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_write_enable) we_cnt <= we_cnt + 1;
        if (if_rsp_valid) if_rsp_cnt <= if_rsp_cnt + 1;
        if (ls_rsp_valid) ls_rsp_cnt <= ls_rsp_cnt + 1;
    end

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        @(negedge clock);
        #1;
        n_chk++;
        if (if_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_if_ready: got %b want 0", if_req_ready);
        end
        n_chk++;
        if (ls_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ls_ready: got %b want 0", ls_req_ready);
        end
        @(negedge clock);
        n_chk++;
        if (mem_addr !== 8'h00 || mem_write_val !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_mem: got %h/%h want 00/0000", mem_addr, mem_write_val);
        end
        n_chk++;
        if (mem_write_enable !== 1'b0 || ls_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_we_err: got %b/%b want 0/0", mem_write_enable, ls_rsp_err);
        end
        n_chk++;
        if ({if_rsp_valid, ls_rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_rsp_valid: got %b%b want 00", if_rsp_valid, ls_rsp_valid);
        end
        n_chk++;
        if (if_rsp_data !== 16'h0 || ls_rsp_data !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_rsp_data: got %h/%h want 0/0", if_rsp_data, ls_rsp_data);
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_load();
        preload(8'h10, 16'hBEEF);
        ls_req_valid = 1'b1;
        ls_req_addr = 8'h10;
        ls_req_write = 1'b0;
        #1;
        n_chk++;
        if (ls_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready: got %b want 1", ls_req_ready);
        end
        @(negedge clock);
        ls_req_valid = 1'b0;
        n_chk++;
        if (ls_rsp_valid !== 1'b0 || mem_addr !== 8'h10) begin
            n_fail++;
            $display("FAIL load_access: got v=%b a=%h want v=0 a=10", ls_rsp_valid, mem_addr);
        end
        @(negedge clock);
        n_chk++;
        if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL load_rsp: got v=%b d=%h want v=1 d=beef", ls_rsp_valid, ls_rsp_data);
        end
        @(negedge clock);
        n_chk++;
        if (ls_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_pulse: got %b want 0", ls_rsp_valid);
        end
    endtask

    task automatic test_store_load();
        int we0;
        we0 = we_cnt;
        ls_req_valid = 1'b1;
        ls_req_addr = 8'h20;
        ls_req_write = 1'b1;
        ls_req_wdata = 16'h1234;
        @(negedge clock);
        n_chk++;
        if (mem_write_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL store_we: got %b want 1", mem_write_enable);
        end
        ls_req_write = 1'b0;
        ls_req_wdata = 16'h0;
        @(negedge clock);
        ls_req_valid = 1'b0;
        n_chk++;
        if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 16'h0) begin
            n_fail++;
            $display("FAIL store_ack: got v=%b d=%h want v=1 d=0", ls_rsp_valid, ls_rsp_data);
        end
        @(negedge clock);
        n_chk++;
        if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL store_load: got v=%b d=%h want v=1 d=1234", ls_rsp_valid, ls_rsp_data);
        end
        n_chk++;
        if (we_cnt - we0 !== 1) begin
            n_fail++;
            $display("FAIL store_we_cnt: got %0d want 1", we_cnt - we0);
        end
        @(negedge clock);
    endtask

    task automatic test_contention();
        logic exp_if [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int if0;
        int ls0;
        logic g_if;
        logic g_ls;
        if0 = if_rsp_cnt;
        ls0 = ls_rsp_cnt;
        if_req_valid = 1'b1;
        if_req_addr = 8'h50;
        ls_req_valid = 1'b1;
        ls_req_addr = 8'h60;
        ls_req_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            g_if = if_req_ready;
            g_ls = ls_req_ready;
            n_chk++;
            if (g_if !== exp_if[i] || g_ls !== !exp_if[i]) begin
                n_fail++;
                $display("FAIL contention_gnt%0d: got if=%b ls=%b want if=%b", i, g_if, g_ls, exp_if[i]);
            end
            @(negedge clock);
            if (g_if) if_req_addr = if_req_addr + 8'd1;
            if (g_ls) ls_req_addr = ls_req_addr + 8'd1;
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        repeat (3) @(negedge clock);
        n_chk++;
        if (if_rsp_cnt - if0 !== 2 || ls_rsp_cnt - ls0 !== 6) begin
            n_fail++;
            $display("FAIL contention_rsp: got if=%0d ls=%0d want 2/6", if_rsp_cnt - if0, ls_rsp_cnt - ls0);
        end
    endtask

    task automatic test_reset_mid();
        int we0;
        int ls0;
        preload(8'h30, 16'h5555);
        we0 = we_cnt;
        ls0 = ls_rsp_cnt;
        ls_req_valid = 1'b1;
        ls_req_addr = 8'h30;
        ls_req_write = 1'b1;
        ls_req_wdata = 16'h9999;
        @(negedge clock);
        ls_req_valid = 1'b0;
        ls_req_write = 1'b0;
        reset = 1'b1;
        #1;
        n_chk++;
        if (mem_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_we: got %b want 0", mem_write_enable);
        end
        @(negedge clock);
        reset = 1'b0;
        n_chk++;
        if (ls_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_rsp: got %b want 0", ls_rsp_valid);
        end
        repeat (2) @(negedge clock);
        n_chk++;
        if (mem[8'h30] !== 16'h5555 || we_cnt !== we0 || ls_rsp_cnt !== ls0) begin
            n_fail++;
            $display("FAIL rstmid_mem: got %h we=%0d rsp=%0d want 5555 0 0", mem[8'h30], we_cnt - we0, ls_rsp_cnt - ls0);
        end
    endtask

    task automatic test_misaligned();
        logic        e_we;
        logic        e_err;
        logic [15:0] e_mem;
`ifdef SHRIMP_ALIGN_CHECK_EN
        e_we = 1'b0;
        e_err = 1'b1;
        e_mem = 16'h7777;
`else
        e_we = 1'b1;
        e_err = 1'b0;
        e_mem = 16'hCAFE;
`endif
        preload(8'h41, 16'h7777);
        ls_req_valid = 1'b1;
        ls_req_addr = 8'h41;
        ls_req_write = 1'b1;
        ls_req_wdata = 16'hCAFE;
        @(negedge clock);
        ls_req_valid = 1'b0;
        ls_req_write = 1'b0;
        n_chk++;
        if (mem_write_enable !== e_we) begin
            n_fail++;
            $display("FAIL misalign_we: got %b want %b", mem_write_enable, e_we);
        end
        @(negedge clock);
        n_chk++;
        if (ls_rsp_valid !== 1'b1 || ls_rsp_err !== e_err || ls_rsp_data !== 16'h0) begin
            n_fail++;
            $display("FAIL misalign_rsp: got v=%b e=%b d=%h want v=1 e=%b d=0", ls_rsp_valid, ls_rsp_err, ls_rsp_data, e_err);
        end
        n_chk++;
        if (mem[8'h41] !== e_mem) begin
            n_fail++;
            $display("FAIL misalign_mem: got %h want %h", mem[8'h41], e_mem);
        end
        @(negedge clock);
    endtask

    task automatic test_throughput();
        for (int i = 0; i < 10; i++) begin
            preload(8'h70 + 8'(i), 16'hC000 + 16'(i));
        end
        for (int t = 0; t < 12; t++) begin
            if (t >= 2) begin
                n_chk++;
                if (if_rsp_valid !== 1'b1 || if_rsp_data !== 16'hC000 + 16'(t - 2)) begin
                    n_fail++;
                    $display("FAIL tput_rsp%0d: got v=%b d=%h want v=1 d=%h", t - 2, if_rsp_valid, if_rsp_data, 16'hC000 + 16'(t - 2));
                end
            end
            if (t < 10) begin
                if_req_valid = 1'b1;
                if_req_addr = 8'h70 + 8'(t);
                #1;
                n_chk++;
                if (if_req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tput_ready%0d: got %b want 1", t, if_req_ready);
                end
            end else begin
                if_req_valid = 1'b0;
            end
            @(negedge clock);
        end
        n_chk++;
        if (if_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tput_end: got %b want 0", if_rsp_valid);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        we_cnt = 0;
        if_rsp_cnt = 0;
        ls_rsp_cnt = 0;
        reset = 1'b1;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        if_req_valid = 1'b0;
        if_req_addr = '0;
        ls_req_valid = 1'b0;
        ls_req_addr = '0;
        ls_req_write = 1'b0;
        ls_req_wdata = '0;
        @(negedge clock);
        test_reset();
        test_single_load();
        test_store_load();
        test_contention();
        test_reset_mid();
        test_misaligned();
        test_throughput();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
